// File: rtl/prim_esc_sender.sv
// Escalation sender: drives the differential esc pair for pings and
// escalations, predicts the receiver's reply and flags integrity errors.
//
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   ping_en_i       ping request level (rising edge starts one ping)
//   esc_en_i        escalation request level
//   esc_rx_i[1:0]   receiver reply pair, [1]=P [0]=N
//   esc_tx_o[1:0]   sender line pair, [1]=P [0]=N
//   ping_ok_o       one-cycle pulse on a clean ping handshake
//   integ_fail_o    high for each cycle after a failed reply check
module prim_esc_sender (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ping_en_i,
  input  logic       esc_en_i,
  input  logic [1:0] esc_rx_i,
  output logic       ping_ok_o,
  output logic       integ_fail_o,
  output logic [1:0] esc_tx_o
);

  typedef enum logic [1:0] {
    MIdle,
    MCheck,
    MPing,
    MEsc
  } mirror_e;

  mirror_e    m_q, m_d;
  logic       exp_q, exp_d;
  logic       ping_en_q;
  logic       ping_busy_q, ping_busy_d;
  logic       ping_line_q;
  logic [2:0] cnt_q, cnt_d;
  logic       abort_q, abort_d;
  logic       ok_d;

  logic ping_edge;
  logic ping_req;
  logic tx_p_d;
  logic lvl;
  logic chk_fail;
  logic counted;
  logic last;

  assign ping_edge = ping_en_i & ~ping_en_q;
  assign ping_req  = ping_edge & ~ping_busy_q & ~esc_en_i;
  assign tx_p_d    = esc_en_i | ping_req;
  assign lvl       = esc_tx_o[1];

  assign chk_fail = (esc_rx_i[1] == esc_rx_i[0]) |
                    (esc_rx_i[1] != exp_q);

  // The cycle the ping itself is on the line is not a counted check.
  assign counted = ping_busy_q & ~ping_line_q;
  assign last    = counted & (cnt_q == 3'd1);

  always_comb begin
    m_d   = m_q;
    exp_d = 1'b0;
    unique case (m_q)
      MIdle: begin
        if (lvl) begin
          m_d   = MCheck;
          exp_d = 1'b1;
        end
      end
      MCheck: begin
        m_d   = lvl ? MEsc : MPing;
        exp_d = 1'b0;
      end
      MPing: begin
        m_d   = lvl ? MEsc : MIdle;
        exp_d = 1'b1;
      end
      MEsc: begin
        m_d   = lvl ? MEsc : MIdle;
        exp_d = lvl ? ~exp_q : 1'b0;
      end
      default: begin
        m_d   = MIdle;
        exp_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    ping_busy_d = ping_busy_q;
    cnt_d       = cnt_q;
    abort_d     = abort_q;
    ok_d        = 1'b0;
    if (ping_req) begin
      ping_busy_d = 1'b1;
      cnt_d       = 3'd4;
      abort_d     = 1'b0;
    end else if (counted) begin
      cnt_d = cnt_q - 3'd1;
      if (chk_fail | lvl) begin
        abort_d = 1'b1;
      end
      if (last) begin
        ping_busy_d = 1'b0;
        ok_d        = ~chk_fail & ~lvl & ~abort_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_q          <= MIdle;
      exp_q        <= 1'b0;
      ping_en_q    <= 1'b0;
      ping_busy_q  <= 1'b0;
      ping_line_q  <= 1'b0;
      cnt_q        <= 3'd0;
      abort_q      <= 1'b0;
      ping_ok_o    <= 1'b0;
      integ_fail_o <= 1'b0;
      esc_tx_o     <= 2'b01;
    end else begin
      m_q          <= m_d;
      exp_q        <= exp_d;
      ping_en_q    <= ping_en_i;
      ping_busy_q  <= ping_busy_d;
      ping_line_q  <= ping_req;
      cnt_q        <= cnt_d;
      abort_q      <= abort_d;
      ping_ok_o    <= ok_d;
      integ_fail_o <= chk_fail;
      esc_tx_o     <= {tx_p_d, ~tx_p_d};
    end
  end

endmodule

// File: tb/tb_prim_esc_sender.sv
// Bench for prim_esc_sender: reset, vector table, directed corner
// sequences and a randomized run against a reply-schedule model.
module tb_prim_esc_sender;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       ping_en_i;
  logic       esc_en_i;
  logic [1:0] esc_rx_i;
  logic       ping_ok_o;
  logic       integ_fail_o;
  logic [1:0] esc_tx_o;

  int n_tests = 0;
  int n_fail  = 0;

  prim_esc_sender dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .ping_en_i   (ping_en_i),
    .esc_en_i    (esc_en_i),
    .esc_rx_i    (esc_rx_i),
    .ping_ok_o   (ping_ok_o),
    .integ_fail_o(integ_fail_o),
    .esc_tx_o    (esc_tx_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       e;
    logic       p;
    logic [1:0] r;
    logic [1:0] tx;
    logic       ok;
    logic       f;
  } vec_t;

  vec_t tbl[10];

  localparam int NR = 3000;
  bit hp   [NR+16];
  bit expv [NR+16];
  bit failed[NR+16];
  bit eok  [NR+16];
  bit efl  [NR+16];

  task automatic chk(string name, logic [3:0] act, logic [3:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got tx/ok/fail=%b required %b", name, act, req);
    end
  endtask

  // Called at a negedge: check this cycle's outputs, drive its inputs.
  task automatic cyc(string tag, int c, logic e, logic p,
                     logic [1:0] r, logic [1:0] etx,
                     logic eok_i, logic ef);
    chk($sformatf("%s c%0d", tag, c),
        {esc_tx_o, ping_ok_o, integ_fail_o}, {etx, eok_i, ef});
    esc_en_i  = e;
    ping_en_i = p;
    esc_rx_i  = r;
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_ni    = 1'b0;
    esc_en_i  = 1'b0;
    ping_en_i = 1'b0;
    esc_rx_i  = 2'b01;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    int t;
    logic e, p, fl, ok, pulse, busy, have, pprev, pvalid, run_idle;
    logic [1:0] r;
    int lastk, ps, run_len, esc_left;
    logic p_lvl;

    rst_ni    = 1'b1;
    esc_en_i  = 1'b0;
    ping_en_i = 1'b0;
    esc_rx_i  = 2'b01;
    #1 rst_ni = 1'b0;

    // Held reset.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      chk($sformatf("reset c%0d", i),
          {esc_tx_o, ping_ok_o, integ_fail_o}, 4'b0100);
    end

    // Nominal ping with a conforming receiver.
    tbl[0] = '{1'b0, 1'b1, 2'b01, 2'b01, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 2'b01, 2'b10, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 2'b10, 2'b01, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 2'b01, 2'b01, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 2'b10, 2'b01, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 2'b01, 2'b01, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 2'b01, 2'b01, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 10; i++)
      cyc("ping", i, tbl[i].e, tbl[i].p, tbl[i].r,
          tbl[i].tx, tbl[i].ok, tbl[i].f);

    // Escalation held cycles 0-4.
    do_reset();
    cyc("esc", 0, 1, 0, 2'b01, 2'b01, 0, 0);
    cyc("esc", 1, 1, 0, 2'b01, 2'b10, 0, 0);
    cyc("esc", 2, 1, 0, 2'b10, 2'b10, 0, 0);
    cyc("esc", 3, 1, 0, 2'b01, 2'b10, 0, 0);
    cyc("esc", 4, 1, 0, 2'b10, 2'b10, 0, 0);
    cyc("esc", 5, 0, 0, 2'b01, 2'b10, 0, 0);
    cyc("esc", 6, 0, 0, 2'b10, 2'b01, 0, 0);
    cyc("esc", 7, 0, 0, 2'b01, 2'b01, 0, 0);
    cyc("esc", 8, 0, 0, 2'b01, 2'b01, 0, 0);
    cyc("esc", 9, 0, 0, 2'b01, 2'b01, 0, 0);

    // Ping with a broken reply in cycle 3.
    do_reset();
    cyc("pfail", 0, 0, 1, 2'b01, 2'b01, 0, 0);
    cyc("pfail", 1, 0, 1, 2'b01, 2'b10, 0, 0);
    cyc("pfail", 2, 0, 1, 2'b10, 2'b01, 0, 0);
    cyc("pfail", 3, 0, 1, 2'b11, 2'b01, 0, 0);
    cyc("pfail", 4, 0, 1, 2'b10, 2'b01, 0, 1);
    cyc("pfail", 5, 0, 1, 2'b01, 2'b01, 0, 0);
    cyc("pfail", 6, 0, 1, 2'b01, 2'b01, 0, 0);
    cyc("pfail", 7, 0, 0, 2'b01, 2'b01, 0, 0);

    // Escalation overlapping a ping.
    do_reset();
    cyc("ovl", 0, 0, 1, 2'b01, 2'b01, 0, 0);
    cyc("ovl", 1, 0, 1, 2'b01, 2'b10, 0, 0);
    cyc("ovl", 2, 1, 1, 2'b10, 2'b01, 0, 0);
    cyc("ovl", 3, 1, 1, 2'b01, 2'b10, 0, 0);
    cyc("ovl", 4, 1, 1, 2'b10, 2'b10, 0, 0);
    cyc("ovl", 5, 1, 1, 2'b01, 2'b10, 0, 0);
    cyc("ovl", 6, 0, 1, 2'b10, 2'b10, 0, 0);
    cyc("ovl", 7, 0, 1, 2'b01, 2'b01, 0, 0);
    cyc("ovl", 8, 0, 0, 2'b01, 2'b01, 0, 0);
    cyc("ovl", 9, 0, 0, 2'b01, 2'b01, 0, 0);

    // Spurious reply while idle.
    do_reset();
    cyc("spur", 0, 0, 0, 2'b01, 2'b01, 0, 0);
    cyc("spur", 1, 0, 0, 2'b01, 2'b01, 0, 0);
    cyc("spur", 2, 0, 0, 2'b10, 2'b01, 0, 0);
    cyc("spur", 3, 0, 0, 2'b01, 2'b01, 0, 1);
    cyc("spur", 4, 0, 0, 2'b01, 2'b01, 0, 0);
    cyc("spur", 5, 0, 0, 2'b01, 2'b01, 0, 0);

    // Reset in the middle of a ping.
    do_reset();
    cyc("rstp", 0, 0, 1, 2'b01, 2'b01, 0, 0);
    cyc("rstp", 1, 0, 1, 2'b01, 2'b10, 0, 0);
    cyc("rstp", 2, 0, 1, 2'b10, 2'b01, 0, 0);
    cyc("rstp", 3, 0, 1, 2'b01, 2'b01, 0, 0);
    esc_en_i  = 1'b1;
    cyc("rstp", 4, 1, 1, 2'b10, 2'b01, 0, 0);
    rst_ni    = 1'b0;
    ping_en_i = 1'b0;
    esc_en_i  = 1'b0;
    esc_rx_i  = 2'b01;
    #1;
    chk("rstp async", {esc_tx_o, ping_ok_o, integ_fail_o}, 4'b0100);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 8; i++)
      cyc("rstp post", i, 0, 0, 2'b01, 2'b01, 0, 0);

    // Randomized run against the reply-schedule model.
    do_reset();
    for (int i = 0; i < NR + 16; i++) begin
      hp[i] = 0; expv[i] = 0; failed[i] = 0;
      eok[i] = 0; efl[i] = 0;
    end
    have = 0; pprev = 0; pvalid = 0; run_idle = 0;
    lastk = 0; ps = 0; run_len = 0; esc_left = 0; p_lvl = 0;
    for (t = 4; t < NR + 4; t++) begin
      chk($sformatf("rnd c%0d", t),
          {esc_tx_o, ping_ok_o, integ_fail_o},
          {hp[t], ~hp[t], eok[t], efl[t]});

      if (esc_left == 0 && $urandom_range(0, 39) == 0)
        esc_left = $urandom_range(1, 6);
      e = (esc_left != 0);
      if (esc_left != 0) esc_left--;
      if ($urandom_range(0, 5) == 0) p_lvl = ~p_lvl;
      p = p_lvl;
      r = {expv[t], ~expv[t]};
      if ($urandom_range(0, 29) == 0) r = 2'($urandom_range(0, 3));
      esc_en_i  = e;
      ping_en_i = p;
      esc_rx_i  = r;

      fl = (r[1] == r[0]) || (r[1] != expv[t]);
      failed[t] = fl;
      efl[t+1]  = fl;
      busy = have && t >= lastk + 1 && t <= lastk + 5;
      ok = 0;
      if (have && t == lastk + 5) begin
        ok = 1;
        for (int c = lastk + 2; c <= lastk + 5; c++)
          if (failed[c] || hp[c]) ok = 0;
      end
      eok[t+1] = ok;
      pulse = p && !pprev && !e && !busy;
      hp[t+1] = e || pulse;
      if (pulse) begin
        have  = 1;
        lastk = t;
      end
      pprev = p;

      // Reply schedule: a run of P=1 is answered by alternating
      // 1,0,... one cycle late, then 0; a lone pulse from idle is a
      // ping and is answered 1,0,1,0 unless a new run interrupts it.
      if (hp[t] && !hp[t-1]) begin
        expv[t+1] = 1;
        run_len   = 1;
        run_idle  = !(pvalid && t == ps + 2);
      end else if (hp[t] && hp[t-1]) begin
        expv[t+1] = !expv[t];
        run_len++;
      end else if (!hp[t] && hp[t-1]) begin
        if (run_len == 1 && run_idle) begin
          expv[t+1] = 0;
          expv[t+2] = 1;
          expv[t+3] = 0;
          ps     = t - 1;
          pvalid = 1;
        end else begin
          expv[t+1] = 0;
        end
      end
      @(negedge clk_i);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
